// File: rtl/mips_muldiv_seq.sv
// Sequential multiply/divide unit producing the HI/LO result pair.
// One multiplier or quotient bit is retired per cycle. Operands are turned into
// magnitudes on accept, and the result signs are restored in a single FIX cycle.
module mips_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [4:0] FS_MUL  = 5'h1A;
  localparam logic [4:0] FS_MULU = 5'h1B;
  localparam logic [4:0] FS_DIV  = 5'h1C;
  localparam logic [4:0] FS_DIVU = 5'h1D;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULU, OP_DIV, OP_DIVU} op_t;

  state_t             state_reg, state_next;
  op_t                op_reg, op_next;
  logic [WIDTH-1:0]   a_reg, a_next;          // |S|: multiplicand
  logic [WIDTH-1:0]   b_reg, b_next;          // |T|: divisor
  logic [WIDTH-1:0]   s_raw_reg, s_raw_next;  // S as latched, for divide-by-zero
  logic               s_neg_reg, s_neg_next;
  logic               t_neg_reg, t_neg_next;
  logic               dz_reg, dz_next;
  logic               ovf_reg, ovf_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;      // product, or quotient in low half
  logic [WIDTH:0]     rem_reg, rem_next;
  logic [WIDTH-1:0]   y_hi_reg, y_hi_next;
  logic [WIDTH-1:0]   y_lo_reg, y_lo_next;
  logic               n_reg, n_next;
  logic               z_reg, z_next;
  logic               v_reg, v_next;
  logic               done_reg, done_next;

  // Decode of the incoming request
  op_t              op_dec;
  logic             fs_ok;
  logic             sgn_in, div_in, s_neg_in, t_neg_in;
  logic [WIDTH-1:0] s_abs, t_abs;

  // Datapath helpers
  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   div_shift, div_diff;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, remd, hi_v, lo_v;

  // Map the function code onto an operation; unknown codes are not accepted
  always_comb begin
    op_dec = OP_MUL;
    fs_ok  = 1'b1;
    case (FS)
      FS_MUL:  op_dec = OP_MUL;
      FS_MULU: op_dec = OP_MULU;
      FS_DIV:  op_dec = OP_DIV;
      FS_DIVU: op_dec = OP_DIVU;
      default: fs_ok  = 1'b0;
    endcase
  end

  assign sgn_in   = (op_dec == OP_MUL) || (op_dec == OP_DIV);
  assign div_in   = (op_dec == OP_DIV) || (op_dec == OP_DIVU);
  assign s_neg_in = sgn_in & S[WIDTH-1];
  assign t_neg_in = sgn_in & T[WIDTH-1];
  assign s_abs    = s_neg_in ? -S : S;
  assign t_abs    = t_neg_in ? -T : T;

  // Shift-add step: the low half holds the unconsumed multiplier bits
  assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
  // Restoring divide step: negative difference means keep the shifted remainder
  assign div_shift = {rem_reg, acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, b_reg};

  assign res_neg = s_neg_reg ^ t_neg_reg;
  assign prod    = res_neg ? -acc_reg : acc_reg;
  assign quo     = res_neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign remd    = s_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

  // Next-state, datapath and result computation
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_raw_next = s_raw_reg;
    s_neg_next = s_neg_reg;
    t_neg_next = t_neg_reg;
    dz_next    = dz_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    y_hi_next  = y_hi_reg;
    y_lo_next  = y_lo_reg;
    n_next     = n_reg;
    z_next     = z_reg;
    v_next     = v_reg;
    done_next  = 1'b0;
    hi_v       = '0;
    lo_v       = '0;

    case (state_reg)
      IDLE: begin
        if (start && fs_ok) begin
          op_next    = op_dec;
          a_next     = s_abs;
          b_next     = t_abs;
          s_raw_next = S;
          s_neg_next = s_neg_in;
          t_neg_next = t_neg_in;
          dz_next    = div_in && (T == '0);
          ovf_next   = (op_dec == OP_DIV) && (S == MIN_VAL) && (T == '1);
          acc_next   = {{WIDTH{1'b0}}, div_in ? s_abs : t_abs};
          rem_next   = '0;
          cnt_next   = '0;
          state_next = (div_in && (T == '0)) ? FIX : CALC;
        end
      end

      CALC: begin
        cnt_next = cnt_reg + 1'b1;
        if (op_reg == OP_MUL || op_reg == OP_MULU) begin
          acc_next = {add_sum, acc_reg[WIDTH-1:1]};
        end else begin
          rem_next = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
          acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end
        if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
      end

      FIX: begin
        case (op_reg)
          OP_MUL, OP_MULU: begin
            hi_v   = prod[2*WIDTH-1:WIDTH];
            lo_v   = prod[WIDTH-1:0];
            z_next = (acc_reg == '0);
            if (op_reg == OP_MUL) begin
              n_next = hi_v[WIDTH-1];
              v_next = (hi_v != {WIDTH{lo_v[WIDTH-1]}});
            end else begin
              n_next = 1'b0;
              v_next = (hi_v != '0);
            end
          end
          default: begin
            if (dz_reg) begin
              lo_v   = '1;
              hi_v   = s_raw_reg;
              v_next = 1'b1;
            end else if (ovf_reg) begin
              lo_v   = MIN_VAL;
              hi_v   = '0;
              v_next = 1'b1;
            end else begin
              lo_v   = quo;
              hi_v   = remd;
              v_next = 1'b0;
            end
            n_next = (op_reg == OP_DIV) ? lo_v[WIDTH-1] : 1'b0;
            z_next = (lo_v == '0);
          end
        endcase
        y_hi_next  = hi_v;
        y_lo_next  = lo_v;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_MUL;
      a_reg     <= '0;
      b_reg     <= '0;
      s_raw_reg <= '0;
      s_neg_reg <= 1'b0;
      t_neg_reg <= 1'b0;
      dz_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      y_hi_reg  <= '0;
      y_lo_reg  <= '0;
      n_reg     <= 1'b0;
      z_reg     <= 1'b0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_raw_reg <= s_raw_next;
      s_neg_reg <= s_neg_next;
      t_neg_reg <= t_neg_next;
      dz_reg    <= dz_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      y_hi_reg  <= y_hi_next;
      y_lo_reg  <= y_lo_next;
      n_reg     <= n_next;
      z_reg     <= z_next;
      v_reg     <= v_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign Y_hi = y_hi_reg;
  assign Y_lo = y_lo_reg;
  assign N    = n_reg;
  assign Z    = z_reg;
  assign V    = v_reg;
  assign C    = 1'b0;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Directed bench for mips_muldiv_seq at WIDTH=32 and WIDTH=8.
module tb_mips_muldiv_seq;

  localparam logic [4:0] F_MUL  = 5'h1A;
  localparam logic [4:0] F_MULU = 5'h1B;
  localparam logic [4:0] F_DIV  = 5'h1C;
  localparam logic [4:0] F_DIVU = 5'h1D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start_a;
  logic [4:0]  fs_a;
  logic [31:0] s_a, t_a, yhi_a, ylo_a;
  logic        busy_a, done_a, n_a, z_a, v_a, c_a;

  logic        start_b;
  logic [4:0]  fs_b;
  logic [7:0]  s_b, t_b, yhi_b, ylo_b;
  logic        busy_b, done_b, n_b, z_b, v_b, c_b;

  int errors = 0;
  int checks = 0;
  int lat;
  logic busy_seen;

  mips_muldiv_seq #(.WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .FS(fs_a), .S(s_a), .T(t_a),
    .busy(busy_a), .done(done_a), .Y_hi(yhi_a), .Y_lo(ylo_a),
    .N(n_a), .Z(z_a), .V(v_a), .C(c_a)
  );

  mips_muldiv_seq #(.WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .FS(fs_b), .S(s_b), .T(t_b),
    .busy(busy_b), .done(done_b), .Y_hi(yhi_b), .Y_lo(ylo_b),
    .N(n_b), .Z(z_b), .V(v_b), .C(c_b)
  );

  // Issue one 32-bit operation, scramble the inputs after accept, wait for done
  task automatic run_a(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    @(posedge clk); #1;
    start_a = 1'b1; fs_a = fs; s_a = s; t_a = t;
    @(posedge clk); #1;
    start_a = 1'b0; fs_a = 5'h00; s_a = 32'hDEAD_BEEF; t_a = 32'h0BAD_F00D;
    busy_seen = busy_a;
    lat = 0;
    while (done_a !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done_a !== 1'b1) lat = -1;
    $display("txn w32 fs=%h S=%h T=%h -> hi=%h lo=%h nzvc=%b lat=%0d",
             fs, s, t, yhi_a, ylo_a, {n_a, z_a, v_a, c_a}, lat);
  endtask

  task automatic run_b(input logic [4:0] fs, input logic [7:0] s, input logic [7:0] t);
    @(posedge clk); #1;
    start_b = 1'b1; fs_b = fs; s_b = s; t_b = t;
    @(posedge clk); #1;
    start_b = 1'b0; fs_b = 5'h00; s_b = 8'hA5; t_b = 8'h5A;
    busy_seen = busy_b;
    lat = 0;
    while (done_b !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done_b !== 1'b1) lat = -1;
    $display("txn w8 fs=%h S=%h T=%h -> hi=%h lo=%h nzvc=%b lat=%0d",
             fs, s, t, yhi_b, ylo_b, {n_b, z_b, v_b, c_b}, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, n_a, z_a, v_a, c_a} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl_a: got %b expected 000000", {busy_a, done_a, n_a, z_a, v_a, c_a});
    end
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0) begin
      errors++; $display("FAIL reset_y_a: got %h expected 0", {yhi_a, ylo_a});
    end
    checks++;
    if ({busy_b, done_b, n_b, z_b, v_b, c_b, yhi_b, ylo_b} !== 22'h0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {busy_b, done_b, n_b, z_b, v_b, c_b, yhi_b, ylo_b});
    end
    reset = 1'b0;
  endtask

  task automatic test_mul_signed();
    run_a(F_MUL, 32'd7, 32'hFFFF_FFFD);
    checks++;
    if (busy_seen !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b expected 1", busy_seen); end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++;
    if ({yhi_a, ylo_a} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mul_result: got %h expected FFFFFFFFFFFFFFEB", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b1000) begin
      errors++; $display("FAIL mul_flags: got %b expected 1000", {n_a, z_a, v_a, c_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL done_pulse: got busy,done=%b expected 00", {busy_a, done_a});
    end
  endtask

  task automatic test_mulu_and_zero();
    run_a(F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({yhi_a, ylo_a} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL mulu_result: got %h expected FFFFFFFE00000001", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b0010) begin
      errors++; $display("FAIL mulu_flags: got %b expected 0010", {n_a, z_a, v_a, c_a});
    end
    run_a(F_MUL, 32'd0, 32'h1234_5678);
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0) begin
      errors++; $display("FAIL mul_zero_result: got %h expected 0", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b0100) begin
      errors++; $display("FAIL mul_zero_flags: got %b expected 0100", {n_a, z_a, v_a, c_a});
    end
  endtask

  task automatic test_div();
    run_a(F_DIV, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if ({yhi_a, ylo_a} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_result: got %h expected FFFFFFFFFFFFFFFD", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b1000) begin
      errors++; $display("FAIL div_flags: got %b expected 1000", {n_a, z_a, v_a, c_a});
    end
    run_a(F_DIVU, 32'd100, 32'd7);
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0000_0002_0000_000E) begin
      errors++; $display("FAIL divu_result: got %h expected 000000020000000E", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b0000 || lat !== 33) begin
      errors++; $display("FAIL divu_flags_lat: got %b/%0d expected 0000/33", {n_a, z_a, v_a, c_a}, lat);
    end
  endtask

  task automatic test_div_special();
    run_a(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_ovf_result: got %h expected 0000000080000000", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b1010) begin
      errors++; $display("FAIL div_ovf_flags: got %b expected 1010", {n_a, z_a, v_a, c_a});
    end
    run_a(F_DIVU, 32'd5, 32'd0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0000_0005_FFFF_FFFF) begin
      errors++; $display("FAIL divz_result: got %h expected 00000005FFFFFFFF", {yhi_a, ylo_a});
    end
    checks++;
    if ({n_a, z_a, v_a, c_a} !== 4'b0010) begin
      errors++; $display("FAIL divz_flags: got %b expected 0010", {n_a, z_a, v_a, c_a});
    end
    run_a(F_DIV, 32'hFFFF_FFF9, 32'd0);
    checks++;
    if ({yhi_a, ylo_a, n_a, z_a, v_a, c_a} !== {64'hFFFF_FFF9_FFFF_FFFF, 4'b1010} || lat !== 1) begin
      errors++; $display("FAIL divz_signed: got %h/%b/%0d expected FFFFFFF9FFFFFFFF/1010/1",
                         {yhi_a, ylo_a}, {n_a, z_a, v_a, c_a}, lat);
    end
  endtask

  task automatic test_ignore_busy();
    @(posedge clk); #1;
    start_a = 1'b1; fs_a = F_MUL; s_a = 32'd7; t_a = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (done_a !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        start_a = 1'b1; fs_a = F_DIVU; s_a = 32'd1; t_a = 32'd1;
      end else begin
        start_a = 1'b0;
      end
    end
    if (done_a !== 1'b1) lat = -1;
    $display("txn w32 MUL with mid-flight start -> hi=%h lo=%h lat=%0d", yhi_a, ylo_a, lat);
    checks++;
    if (lat !== 33 || {yhi_a, ylo_a} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL ignore_busy: got %h lat=%0d expected FFFFFFFFFFFFFFEB lat=33", {yhi_a, ylo_a}, lat);
    end
  endtask

  task automatic test_bad_fs();
    int seen_done;
    @(posedge clk); #1;
    start_a = 1'b1; fs_a = 5'h02; s_a = 32'd1; t_a = 32'd1;
    @(posedge clk); #1;
    start_a = 1'b0;
    $display("txn w32 fs=02 in idle -> busy=%b", busy_a);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a === 1'b1 || busy_a !== 1'b0) seen_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL bad_fs_idle: got %0d active cycles expected 0", seen_done); end
    checks++;
    if (ylo_a !== 32'hFFFF_FFEB) begin errors++; $display("FAIL bad_fs_hold: got %h expected FFFFFFEB", ylo_a); end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    @(posedge clk); #1;
    start_a = 1'b1; fs_a = F_DIV; s_a = 32'd100; t_a = 32'd7;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("txn w32 DIV aborted by reset -> busy=%b done=%b hi=%h lo=%h", busy_a, done_a, yhi_a, ylo_a);
    checks++;
    if ({busy_a, done_a, n_a, z_a, v_a, c_a, yhi_a, ylo_a} !== 70'h0) begin
      errors++; $display("FAIL abort_clear: got %h expected 0", {busy_a, done_a, n_a, z_a, v_a, c_a, yhi_a, ylo_a});
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1 || busy_a !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done); end
    run_a(F_MUL, 32'd3, 32'd4);
    checks++;
    if ({yhi_a, ylo_a} !== 64'h0000_0000_0000_000C || lat !== 33) begin
      errors++; $display("FAIL after_abort_mul: got %h lat=%0d expected 000000000000000C lat=33", {yhi_a, ylo_a}, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    start_a = 1'b1; fs_a = F_MULU; s_a = 32'd3; t_a = 32'd5;
    @(posedge clk); #1;
    lat = 0;
    while (done_a !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (ylo_a !== 32'd15 || lat !== 33) begin
      errors++; $display("FAIL b2b_first: got %h lat=%0d expected 0000000F lat=33", ylo_a, lat);
    end
    s_a = 32'd6;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy_a); end
    lat = 0;
    while (done_a !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn w32 back-to-back MULU 6x5 -> lo=%h lat=%0d", ylo_a, lat);
    checks++;
    if (ylo_a !== 32'd30 || lat !== 33) begin
      errors++; $display("FAIL b2b_second: got %h lat=%0d expected 0000001E lat=33", ylo_a, lat);
    end
  endtask

  task automatic test_width8();
    run_b(F_MUL, 8'd7, 8'hFD);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL w8_mul_latency: got %0d expected 9", lat); end
    checks++;
    if ({yhi_b, ylo_b, n_b, z_b, v_b, c_b} !== {16'hFFEB, 4'b1000}) begin
      errors++; $display("FAIL w8_mul: got %h/%b expected FFEB/1000", {yhi_b, ylo_b}, {n_b, z_b, v_b, c_b});
    end
    run_b(F_DIV, 8'hF9, 8'd2);
    checks++;
    if ({yhi_b, ylo_b, n_b} !== {16'hFFFD, 1'b1} || lat !== 9) begin
      errors++; $display("FAIL w8_div: got %h N=%b lat=%0d expected FFFD N=1 lat=9", {yhi_b, ylo_b}, n_b, lat);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; fs_a = 5'h00; s_a = '0; t_a = '0;
    start_b = 1'b0; fs_b = 5'h00; s_b = '0; t_b = '0;
    test_reset();
    test_mul_signed();
    test_mulu_and_zero();
    test_div();
    test_div_special();
    test_ignore_busy();
    test_bad_fs();
    test_reset_abort();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_muldiv_seq.md
# mips_muldiv_seq

Parametrised sequential multiply/divide unit for the enhanced MIPS datapath. It sits beside the combinational ALU and shares its S/T operand buses and 5-bit FS code space, using the FS codes the ALU leaves free. It computes the Y_hi/Y_lo result pair (HI/LO), which the combinational ALU always drives to zero. Operations are iterative, one bit per cycle, with a start/busy/done handshake toward the control unit.

## Interface
- WIDTH, 32, operand width in bits; legal range 4..64.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state and outputs.
- start  input  1  request; sampled only in IDLE.
- FS  input  5  function select, sampled with start: 5'h1A MUL (signed), 5'h1B MULU, 5'h1C DIV (signed), 5'h1D DIVU.
- S  input  WIDTH  multiplicand / dividend.
- T  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; Y_hi, Y_lo and flags are valid from this cycle on.
- Y_hi  output  WIDTH  MUL: product upper half; DIV: remainder.
- Y_lo  output  WIDTH  MUL: product lower half; DIV: quotient.
- N, Z, V, C  output  1 each  negative, zero, overflow and carry flags for the last completed operation.

## Operation
- States are IDLE, CALC and FIX.
- In IDLE with start=1 and FS in 1A..1D:
  - Latch the operation and |S|, |T| (magnitudes for signed ops; raw values for unsigned ops).
  - Record the result sign.
  - Clear the counter, enter CALC and set busy=1.
- start in IDLE with any other FS code: ignored, stay IDLE.
- start while busy: ignored. S, T and FS may change freely after acceptance.
- MUL/MULU in CALC: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
- DIV/DIVU in CALC: restoring division, one quotient bit per cycle, WIDTH cycles. Remainder register is WIDTH+1 bits.
- FIX is one cycle:
  - Apply two's-complement sign correction: product sign = S⊕T; quotient sign = S⊕T; remainder sign = sign of S.
  - Quotient truncates toward zero.
  - Register Y_hi, Y_lo and the flags; pulse done; clear busy; return to IDLE.
- Division by zero (T=0 on a DIV/DIVU accept):
  - Go straight to FIX and skip CALC.
  - Result: Y_lo = all ones, Y_hi = S as latched, V=1.
- Signed DIV with S = MIN and T = −1: Y_lo = MIN, Y_hi = 0, V=1.
- Flags:
  - MUL: N = Y_hi[MSB]; Z = full 2·WIDTH product is zero; V = Y_hi is not the sign-extension of Y_lo.
  - MULU: N = 0; Z as for MUL; V = (Y_hi ≠ 0).
  - DIV: N = Y_lo[MSB]; Z = (Y_lo == 0); V as defined above, else 0.
  - DIVU: N = 0; Z = (Y_lo == 0); V as defined above, else 0.
  - C = 0 for all operations.
- Y_hi, Y_lo and the flags hold their values until the next FIX.

## Timing
- Reset values: state IDLE, busy=0, done=0, Y_hi=0, Y_lo=0, N=Z=V=C=0.
- Reset during CALC or FIX aborts the operation; done never pulses for it.
- Accept edge k → busy=1 after edge k.
- Normal operation: CALC spans edges k+1..k+WIDTH. FIX completes at edge k+WIDTH+1, so done=1 and busy=0 for the cycle after it. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Division by zero: FIX at edge k+1; done is visible one cycle after accept.
- start held high across done: the next operation is accepted at the first edge in IDLE. No back-to-back accept occurs on the same edge as FIX.
- Counter width: $clog2(WIDTH)+1 bits; no wrap occurs within a single operation.

## Test plan
- WIDTH=32. MUL with S=7, T=−3 (0xFFFFFFFD) → done exactly 33 cycles after accept; Y_hi=FFFFFFFF, Y_lo=FFFFFFEB, N=1, Z=0, V=0.
- MULU with S=T=FFFFFFFF → Y_hi=FFFFFFFE, Y_lo=00000001, N=0, V=1. Then MUL with S=0, T=12345678 → Y_hi=Y_lo=0, Z=1.
- DIV with −7 / 2 → Y_lo=FFFFFFFD, Y_hi=FFFFFFFF, N=1. DIVU with 100 / 7 → Y_lo=0000000E, Y_hi=00000002, N=0.
- DIV with 80000000 / FFFFFFFF → Y_lo=80000000, Y_hi=0, V=1. DIVU with 5 / 0 → done 1 cycle after accept, Y_lo=FFFFFFFF, Y_hi=00000005, V=1.
- Pulse start with a new FS/S/T at cycle 5 of a MUL → ignored; the original result is unchanged. start with FS=5'h02 in IDLE → busy stays 0 and no done.
- Assert reset at cycle 10 of a DIV → busy=0, done=0 and all outputs 0 on the next cycle. A subsequent MUL 3×4 → Y_lo=0000000C after 33 cycles.
- Repeat the first and third scenarios with WIDTH=8: MUL 7×(−3) → Y_hi=FF, Y_lo=EB, latency 9 cycles.
